// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin arbiter sharing one main_memory port (one write plus
//            one registered read per cycle) among NUM_REQ requesters, with a
//            lock for atomic multi-beat sequences and 1-cycle read responses.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    output logic [ADDR_W-1:0]         mem_rd_addr,
    input  logic [DATA_W-1:0]         mem_rd_data,
    output logic                      lock_busy
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   w_rr_ptr_nxt;
    logic [c_PTR_W-1:0]   r_lock_owner;
    logic [c_PTR_W-1:0]   w_lock_owner_nxt;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [NUM_REQ-1:0]   w_rsp_valid_nxt;

    logic [ADDR_W-1:0]    w_addr  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata [NUM_REQ];
    logic [c_PTR_W-1:0]   w_cand  [NUM_REQ];

    logic                 w_arb_found;
    logic [c_PTR_W-1:0]   w_arb_idx;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic [c_PTR_W-1:0]   w_grant_inc;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_accept;
    logic                 w_sel_we;
    logic                 w_sel_lock;
    logic                 w_wr_acc;
    logic                 w_rd_acc;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_addr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            assign w_wdata[i] = req_wdata[i*DATA_W +: DATA_W];
        end
        // Candidate k is the requester searched k-th, starting at rr_ptr.
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_scan
            assign w_cand[k] = c_PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        end
    endgenerate

    // Descending scan so the earliest candidate in round-robin order wins.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand[k];
            end
        end
    end

    always_comb begin
        w_grant_idx = '0;
        w_ready     = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_grant_idx = w_arb_idx;
                    w_ready     = w_arb_found ? (c_ONE << w_arb_idx) : '0;
                end
                ST_LOCKED: begin
                    w_grant_idx = r_lock_owner;
                    w_ready     = c_ONE << r_lock_owner;
                end
                default: begin
                    w_grant_idx = '0;
                    w_ready     = '0;
                end
            endcase
        end
    end

    assign w_accept    = |(req_valid & w_ready);
    assign w_sel_we    = req_we[w_grant_idx];
    assign w_sel_lock  = req_lock[w_grant_idx];
    assign w_wr_acc    = w_accept & w_sel_we;
    assign w_rd_acc    = w_accept & ~w_sel_we;
    assign w_grant_inc = (w_grant_idx == c_LAST) ? '0 : w_grant_idx + 1'b1;

    assign req_ready   = w_ready;
    assign mem_wr_en   = w_wr_acc;
    assign mem_wr_addr = w_wr_acc ? w_addr[w_grant_idx]  : '0;
    assign mem_wr_data = w_wr_acc ? w_wdata[w_grant_idx] : '0;
    assign mem_rd_addr = w_rd_acc ? w_addr[w_grant_idx]  : '0;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = mem_rd_data;
    assign lock_busy   = (r_state == ST_LOCKED);

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_owner_nxt = r_lock_owner;
        w_rsp_valid_nxt  = w_rd_acc ? w_ready : '0;
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    w_rr_ptr_nxt = w_grant_inc;
                    if (w_sel_lock) begin
                        w_state_nxt      = ST_LOCKED;
                        w_lock_owner_nxt = w_grant_idx;
                    end
                end
                ST_LOCKED: begin
                    // rr_ptr stays frozen until the owner releases the lock.
                    if (!w_sel_lock) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = w_grant_inc;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_rsp_valid  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Vector-table bench for mem_port_arbiter with a 1-cycle memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_we, req_lock;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]   req_ready, rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         mem_wr_en;
    logic [31:0]  mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;
    logic         lock_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int row    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .lock_busy(lock_busy)
    );

    // Main memory model: registered read, write lands at the clock edge.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
        end else if (mem_wr_en) begin
            mem[mem_wr_addr[7:0]] <= mem_wr_data;
        end
        mem_rd_data <= mem[mem_rd_addr[7:0]];
    end

    function automatic logic [31:0] m(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    typedef struct {
        logic         rst;
        logic [3:0]   v, we, lk;
        logic [127:0] addr, wd;
        logic [3:0]   e_rdy, e_rsp;
        logic [31:0]  e_rdata;
        logic         e_wen;
        logic [31:0]  e_waddr, e_wdata, e_raddr;
        logic         e_lb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] v, we, lk,
                       input logic [127:0] addr, wd,
                       input logic [3:0] erdy, ersp, input logic [31:0] erdata,
                       input logic ewen, input logic [31:0] ewaddr, ewdata, eraddr,
                       input logic elb);
        vec_t t;
        t.rst = r; t.v = v; t.we = we; t.lk = lk; t.addr = addr; t.wd = wd;
        t.e_rdy = erdy; t.e_rsp = ersp; t.e_rdata = erdata; t.e_wen = ewen;
        t.e_waddr = ewaddr; t.e_wdata = ewdata; t.e_raddr = eraddr; t.e_lb = elb;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, we, lk,
                         input logic [127:0] addr, wd);
        rst = r; req_valid = v; req_we = we; req_lock = lk;
        req_addr = addr; req_wdata = wd;
    endtask

    localparam logic [127:0] A   = {32'h40, 32'h30, 32'h20, 32'h10};
    localparam logic [127:0] B   = {32'h40, 32'h08, 32'h08, 32'h10};
    localparam logic [127:0] Z   = '0;
    localparam logic [127:0] WD1 = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    localparam logic [127:0] WD0 = {32'h0, 32'h0, 32'h0, 32'h12345678};
    localparam logic [127:0] WDF = {4{32'hA5A5_5A5A}};

    initial begin
        // reset gating of combinational outputs
        add(1, 4'hF, 0, 0, A, Z,   4'h0, 4'h0, 0, 0, 0, 0, 32'h00, 0);
        // all four reading: grants 0,1,2,3,0
        add(0, 4'hF, 0, 0, A, Z,   4'h1, 4'h0, 0,         0, 0, 0, 32'h10, 0);
        add(0, 4'hF, 0, 0, A, Z,   4'h2, 4'h1, m(32'h10), 0, 0, 0, 32'h20, 0);
        add(0, 4'hF, 0, 0, A, Z,   4'h4, 4'h2, m(32'h20), 0, 0, 0, 32'h30, 0);
        add(0, 4'hF, 0, 0, A, Z,   4'h8, 4'h4, m(32'h30), 0, 0, 0, 32'h40, 0);
        add(0, 4'hF, 0, 0, A, Z,   4'h1, 4'h8, m(32'h40), 0, 0, 0, 32'h10, 0);
        // write then read-after-write
        add(0, 4'h2, 4'h2, 0, B, WD1, 4'h2, 4'h1, m(32'h10), 1, 32'h08, 32'hDEADBEEF, 0, 0);
        add(0, 4'h4, 0, 0, B, WD1, 4'h4, 4'h0, 0,            0, 0, 0, 32'h08, 0);
        add(0, 4'h0, 0, 0, B, WD1, 4'h0, 4'h4, 32'hDEADBEEF, 0, 0, 0, 32'h00, 0);
        // steer rr_ptr to 1
        add(0, 4'h8, 0, 0, A, Z,   4'h8, 4'h0, 0,         0, 0, 0, 32'h40, 0);
        add(0, 4'h1, 0, 0, A, Z,   4'h1, 4'h8, m(32'h40), 0, 0, 0, 32'h10, 0);
        // req2 locks 3 beats with req0/req3 waiting
        add(0, 4'hD, 0, 4'h4, A, Z, 4'h4, 4'h1, m(32'h10), 0, 0, 0, 32'h30, 0);
        add(0, 4'hD, 0, 4'h4, A, Z, 4'h4, 4'h4, m(32'h30), 0, 0, 0, 32'h30, 1);
        add(0, 4'hD, 0, 4'h0, A, Z, 4'h4, 4'h4, m(32'h30), 0, 0, 0, 32'h30, 1);
        add(0, 4'hD, 0, 4'h0, A, Z, 4'h8, 4'h4, m(32'h30), 0, 0, 0, 32'h40, 0);
        // wrap-around 3 -> 0
        add(0, 4'h4, 0, 0, A, Z,   4'h4, 4'h8, m(32'h40), 0, 0, 0, 32'h30, 0);
        add(0, 4'h9, 0, 0, A, Z,   4'h8, 4'h4, m(32'h30), 0, 0, 0, 32'h40, 0);
        add(0, 4'h9, 0, 0, A, Z,   4'h1, 4'h8, m(32'h40), 0, 0, 0, 32'h10, 0);
        // lock held while owner idle, released by a write
        add(0, 4'h1, 0, 4'h1, A, Z,   4'h1, 4'h1, m(32'h10), 0, 0, 0, 32'h10, 0);
        add(0, 4'h2, 0, 4'h0, A, Z,   4'h1, 4'h1, m(32'h10), 0, 0, 0, 32'h00, 1);
        add(0, 4'h3, 4'h1, 0, A, WD0, 4'h1, 4'h0, 0, 1, 32'h10, 32'h12345678, 0, 1);
        add(0, 4'h3, 0, 0, A, Z,   4'h2, 4'h0, 0,         0, 0, 0, 32'h20, 0);
        add(0, 4'h1, 0, 0, A, Z,   4'h1, 4'h2, m(32'h20), 0, 0, 0, 32'h10, 0);
        add(0, 4'h0, 0, 0, A, Z,   4'h0, 4'h1, 32'h12345678, 0, 0, 0, 32'h00, 0);
        // idle: everything quiet despite noisy we/lock/addr/data
        for (int i = 0; i < 5; i++)
            add(0, 4'h0, 4'hF, 4'hF, A, WDF, 4'h0, 4'h0, 0, 0, 0, 0, 32'h00, 0);

        drive(1, 0, 0, 0, Z, Z);
        repeat (3) @(posedge clk);

        foreach (vecs[i]) begin
            row = i;
            @(posedge clk); #1;
            drive(vecs[i].rst, vecs[i].v, vecs[i].we, vecs[i].lk, vecs[i].addr, vecs[i].wd);
            @(negedge clk);
            chk("req_ready",   {28'h0, req_ready}, {28'h0, vecs[i].e_rdy});
            chk("rsp_valid",   {28'h0, rsp_valid}, {28'h0, vecs[i].e_rsp});
            if (vecs[i].e_rsp != 4'h0) chk("rsp_rdata", rsp_rdata, vecs[i].e_rdata);
            chk("mem_wr_en",   {31'h0, mem_wr_en}, {31'h0, vecs[i].e_wen});
            chk("mem_wr_addr", mem_wr_addr, vecs[i].e_waddr);
            chk("mem_wr_data", mem_wr_data, vecs[i].e_wdata);
            chk("mem_rd_addr", mem_rd_addr, vecs[i].e_raddr);
            chk("lock_busy",   {31'h0, lock_busy}, {31'h0, vecs[i].e_lb});
        end

        // Reset while LOCKED with a read in flight (rr_ptr is 1 here).
        row = 1000;
        @(posedge clk); #1;
        drive(0, 4'h2, 4'h0, 4'h2, A, Z);
        @(negedge clk);
        chk("pre_rst_ready", {28'h0, req_ready}, 32'h2);
        chk("pre_rst_rd_addr", mem_rd_addr, 32'h20);
        row = 1001;
        @(posedge clk); #1;
        drive(1, 4'hF, 4'h0, 4'h0, A, Z);
        @(negedge clk);
        chk("rst_ready_gated", {28'h0, req_ready}, 32'h0);
        chk("rst_rsp_pending", {28'h0, rsp_valid}, 32'h2);
        chk("rst_wr_en", {31'h0, mem_wr_en}, 32'h0);
        row = 1002;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_rsp_dropped", {28'h0, rsp_valid}, 32'h0);
        chk("rst_lock_busy", {31'h0, lock_busy}, 32'h0);
        row = 1003;
        @(posedge clk); #1;
        drive(0, 4'hF, 4'h0, 4'h0, A, Z);
        @(negedge clk);
        chk("post_rst_grant", {28'h0, req_ready}, 32'h1);
        chk("post_rst_rd_addr", mem_rd_addr, 32'h10);
        chk("post_rst_rsp", {28'h0, rsp_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
